db15_joy_responder: RTL and testbench
=====================================

// Module: db15_joy_responder
// PURPOSE
//  Device-side end of the serial DB15 joystick link: emulates the external adapter's 74HC165 chain.
//  The host controller drives JOY_LOAD/JOY_CLK; this block answers on JOY_DATA.
//  Used in self-test images and in the sim bench as the stimulus source for the host-side DB15 reader.
//  Also used on boards that re-export local pads to another MiSTer over the SNAC port.
// PARAMETERS
//  BITS_PER_PLAYER  12   buttons per player word; frame length = 2*BITS_PER_PLAYER
//  SYNC_STAGES      2    synchronizer depth on JOY_CLK/JOY_LOAD (min 2)
//  IDLE_TIMEOUT     2^20 clk cycles without a load pulse before link_idle asserts
// PORTS
//  clk            in   1          system clock (>= 8x JOY_CLK rate)
//  reset_n        in   1          asynchronous active-low reset
//  joystick1      in   BPP        player 1 buttons, active-high, bit0 first on wire
//  joystick2      in   BPP        player 2 buttons, active-high
//  JOY_CLK        in   1          host shift clock, async
//  JOY_LOAD       in   1          host load strobe, async, active-low (low = parallel load)
//  JOY_DATA       out  1          serial data to host, active-low buttons
//  link_idle      out  1          no load strobe seen for IDLE_TIMEOUT cycles
//  frame_done     out  1          1-clk pulse when the last frame bit has been shifted out
// BEHAVIOUR
//  - Reset values: shift reg all 1s, JOY_DATA=1, link_idle=1, frame_done=0, bit counter=0, idle counter=0.
//  - JOY_CLK/JOY_LOAD pass through SYNC_STAGES flops. Edges come from the last stage vs a delay flop.
//    Input-to-action latency is SYNC_STAGES+1 clk.
//  - States: IDLE (reset, no load yet), LOADING (sync LOAD low), SHIFT (LOAD high, bits remaining), DRAINED (all bits out).
//  - LOADING: every clk, shift reg <= ~{joystick2, joystick1} and bit counter <= 0.
//    Snapshot is continuous while LOAD is low. The value captured on the last low cycle is the frame.
//    JOY_DATA = ~joystick1[0] during LOADING, as with a transparent 165 load.
//  - Rising edge of sync JOY_CLK in SHIFT: shift reg >> 1 with serial-in 1; counter++.
//    When counter reaches 2*BPP-1 on that edge: pulse frame_done, go to DRAINED.
//  - Falling JOY_CLK edges are ignored. JOY_CLK edges in LOADING are ignored (load dominates).
//  - DRAINED: further JOY_CLK edges keep shifting 1s; JOY_DATA stays 1 (released); counter saturates.
//  - JOY_DATA = shift reg bit0, registered. Updates 1 clk after the shift decision.
//  - Load falling edge in SHIFT (short frame): abort, enter LOADING; no frame_done pulse.
//  - Idle counter clears on any sync LOAD falling edge and saturates at IDLE_TIMEOUT.
//    link_idle = (counter == IDLE_TIMEOUT). It deasserts 1 clk after the load edge.
//  - Simultaneous LOAD fall and JOY_CLK rise (same clk after sync): load wins; the shift is dropped.
//  - reset_n low mid-frame: immediate return to reset values; the next frame starts only on a new load.
//  - joystick1/2 may change at any time. Only the snapshot taken while LOAD is low is transmitted; no tearing within a frame.
// CONFIGURATION
//  DB15_RESP_STATS_EN defined: adds outputs frame_cnt[15:0] and short_cnt[7:0].
//   frame_cnt increments on frame_done and wraps. short_cnt increments on each short-frame abort and saturates at 255.
//   Both reset to 0.
//  Not defined: those ports do not exist and no counters are synthesised; all other behaviour is identical.
// TESTING
//  1. Hold reset_n=0 for 5 clk, release -> JOY_DATA=1, link_idle=1, frame_done=0.
//  2. joystick1=12'h001, joystick2=12'h800; LOAD low 4 JOY_CLK periods, then 24 JOY_CLK rises.
//     -> bits seen on wire: 0,1x22,0; frame_done pulses once, after the 24th rise.
//  3. After frame, 3 extra JOY_CLK rises -> JOY_DATA=1 each; no second frame_done.
//  4. Load, 10 rises, load again with joystick1=12'hFFF -> first 12 bits all 0.
//     No frame_done for the aborted frame; short_cnt=1 with DB15_RESP_STATS_EN.
//  5. No load for IDLE_TIMEOUT clk -> link_idle=1. Then one LOAD pulse -> link_idle=0 within SYNC_STAGES+2 clk.
//  6. Assert reset_n low after 7 shifts -> JOY_DATA=1 immediately.
//     JOY_CLK rises without a load -> JOY_DATA stays 1.

Source files
------------

// File: rtl/db15_joy_responder.sv
// Device-side DB15 joystick responder: emulates the adapter's 74HC165 chain answering JOY_LOAD/JOY_CLK.
// Optional statistics outputs (frame_cnt, short_cnt) are enabled by defining DB15_RESP_STATS_EN.
module db15_joy_responder #(
    parameter int unsigned BITS_PER_PLAYER = 12,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned IDLE_TIMEOUT    = 1 << 20
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [BITS_PER_PLAYER-1:0] joystick1,
    input  logic [BITS_PER_PLAYER-1:0] joystick2,
    input  logic                       JOY_CLK,
    input  logic                       JOY_LOAD,
    output logic                       JOY_DATA,
    output logic                       link_idle,
    output logic                       frame_done
`ifdef DB15_RESP_STATS_EN
    ,
    output logic [15:0]                frame_cnt,
    output logic [7:0]                 short_cnt
`endif
);

    localparam int unsigned FRAME  = 2 * BITS_PER_PLAYER;
    localparam int unsigned CNT_W  = $clog2(FRAME + 1);
    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOADING,
        ST_SHIFT,
        ST_DRAINED
    } state_t;

    state_t                 r_state;
    logic [FRAME-1:0]       r_shift;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_data;
    logic                   r_frame_done;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_load_sync;
    logic                   r_clk_d;
    logic                   r_load_d;

    logic [IDLE_W-1:0]      r_idle_cnt;
    logic                   r_link_idle;

    logic                   w_clk_s;
    logic                   w_load_s;
    logic                   w_clk_rise;
    logic                   w_load_fall;
    logic                   w_load_low;

`ifdef DB15_RESP_STATS_EN
    logic [15:0]            r_frame_cnt;
    logic [7:0]             r_short_cnt;
`endif

    // Synchronizers idle at the inactive levels: JOY_CLK low, JOY_LOAD high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync  <= '0;
            r_load_sync <= '1;
            r_clk_d     <= 1'b0;
            r_load_d    <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], JOY_CLK};
            r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], JOY_LOAD};
            r_clk_d     <= r_clk_sync[SYNC_STAGES-1];
            r_load_d    <= r_load_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        w_clk_s     = r_clk_sync[SYNC_STAGES-1];
        w_load_s    = r_load_sync[SYNC_STAGES-1];
        w_clk_rise  = w_clk_s & ~r_clk_d;
        w_load_fall = r_load_d & ~w_load_s;
        w_load_low  = ~w_load_s;
    end

    // Load has priority over every state, which also drops a coincident JOY_CLK rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_shift      <= '1;
            r_bit_cnt    <= '0;
            r_data       <= 1'b1;
            r_frame_done <= 1'b0;
`ifdef DB15_RESP_STATS_EN
            r_frame_cnt  <= '0;
            r_short_cnt  <= '0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            r_data       <= r_shift[0];
            if (w_load_low) begin
                r_state   <= ST_LOADING;
                r_shift   <= ~{joystick2, joystick1};
                r_bit_cnt <= '0;
`ifdef DB15_RESP_STATS_EN
                if ((r_state == ST_SHIFT) && (r_short_cnt != '1)) begin
                    r_short_cnt <= r_short_cnt + 8'd1;
                end
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_LOADING: begin
                        r_state <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (w_clk_rise) begin
                            r_shift   <= {1'b1, r_shift[FRAME-1:1]};
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            if (r_bit_cnt == LAST_BIT) begin
                                r_frame_done <= 1'b1;
                                r_state      <= ST_DRAINED;
`ifdef DB15_RESP_STATS_EN
                                r_frame_cnt  <= r_frame_cnt + 16'd1;
`endif
                            end
                        end
                    end
                    ST_DRAINED: begin
                        if (w_clk_rise) begin
                            r_shift <= {1'b1, r_shift[FRAME-1:1]};
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // link_idle powers up asserted and stays so until the first load strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt  <= '0;
            r_link_idle <= 1'b1;
        end else if (w_load_fall) begin
            r_idle_cnt  <= '0;
            r_link_idle <= 1'b0;
        end else if (r_idle_cnt != IDLE_MAX) begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            if (r_idle_cnt == (IDLE_MAX - IDLE_W'(1))) begin
                r_link_idle <= 1'b1;
            end
        end
    end

    assign JOY_DATA   = r_data;
    assign link_idle  = r_link_idle;
    assign frame_done = r_frame_done;

`ifdef DB15_RESP_STATS_EN
    assign frame_cnt = r_frame_cnt;
    assign short_cnt = r_short_cnt;
`endif

endmodule

// File: tb/tb_db15_joy_responder.sv
// Directed bench for db15_joy_responder: reset, full frame, drain, short-frame abort, idle timeout, mid-frame reset.
module tb_db15_joy_responder;

    localparam int unsigned BPP     = 12;
    localparam int unsigned TIMEOUT = 200;

    logic        clk;
    logic        reset_n;
    logic [11:0] joystick1;
    logic [11:0] joystick2;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic        JOY_DATA;
    logic        link_idle;
    logic        frame_done;
`ifdef DB15_RESP_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  short_cnt;
`endif

    int vectors;
    int miscompares;

    db15_joy_responder #(
        .BITS_PER_PLAYER(BPP),
        .SYNC_STAGES    (2),
        .IDLE_TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .joystick1 (joystick1),
        .joystick2 (joystick2),
        .JOY_CLK   (JOY_CLK),
        .JOY_LOAD  (JOY_LOAD),
        .JOY_DATA  (JOY_DATA),
        .link_idle (link_idle),
        .frame_done(frame_done)
`ifdef DB15_RESP_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .short_cnt (short_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One JOY_CLK period of 16 system clocks; counts frame_done samples seen.
    task automatic do_rise(output int pulses);
        pulses = 0;
        JOY_CLK = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (frame_done) pulses++;
        end
        JOY_CLK = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (frame_done) pulses++;
        end
    endtask

    // LOAD low for 4 JOY_CLK periods, then settle into shifting.
    task automatic do_load(input logic [11:0] j1, input logic [11:0] j2, output int pulses);
        pulses    = 0;
        joystick1 = j1;
        joystick2 = j2;
        JOY_LOAD  = 1'b0;
        repeat (64) begin
            @(negedge clk);
            if (frame_done) pulses++;
        end
        JOY_LOAD = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (frame_done) pulses++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (JOY_DATA !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_joy_data got=%b exp=1", JOY_DATA);
        end
        vectors++;
        if (link_idle !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_link_idle got=%b exp=1", link_idle);
        end
        vectors++;
        if (frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_frame_done got=%b exp=0", frame_done);
        end
    endtask

    task automatic test_full_frame;
        logic [23:0] exp_bits;
        int          p;
        int          early;
        int          last;
        exp_bits = 24'h7F_FFFE;    // ~{12'h800, 12'h001}
        early    = 0;
        last     = 0;
        do_load(12'h001, 12'h800, p);
        early += p;
        for (int i = 0; i < 24; i++) begin
            vectors++;
            if (JOY_DATA !== exp_bits[i]) begin
                miscompares++;
                $display("FAIL frame_bit%0d got=%b exp=%b", i, JOY_DATA, exp_bits[i]);
            end
            do_rise(p);
            if (i == 23) last = p;
            else early += p;
        end
        vectors++;
        if (early !== 0) begin
            miscompares++;
            $display("FAIL frame_done_early got=%0d exp=0", early);
        end
        vectors++;
        if (last !== 1) begin
            miscompares++;
            $display("FAIL frame_done_after_24th got=%0d exp=1", last);
        end
`ifdef DB15_RESP_STATS_EN
        vectors++;
        if (frame_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL frame_cnt_after_first got=%0d exp=1", frame_cnt);
        end
`endif
    endtask

    task automatic test_drained;
        int p;
        int total;
        total = 0;
        for (int i = 0; i < 3; i++) begin
            do_rise(p);
            total += p;
            vectors++;
            if (JOY_DATA !== 1'b1) begin
                miscompares++;
                $display("FAIL drained_bit%0d got=%b exp=1", i, JOY_DATA);
            end
        end
        vectors++;
        if (total !== 0) begin
            miscompares++;
            $display("FAIL drained_frame_done got=%0d exp=0", total);
        end
    endtask

    // Abort after 10 rises; reload coincides with a JOY_CLK rise; inputs change mid-frame.
    task automatic test_short_frame;
        logic [23:0] exp_bits;
        int          p;
        int          early;
        int          last;
        early = 0;
        last  = 0;
        do_load(12'h001, 12'h800, p);
        early += p;
        for (int i = 0; i < 10; i++) begin
            do_rise(p);
            early += p;
        end
        joystick1 = 12'hFFF;
        JOY_LOAD  = 1'b0;
        JOY_CLK   = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (frame_done) early++;
        end
        JOY_CLK = 1'b0;
        repeat (56) begin
            @(negedge clk);
            if (frame_done) early++;
        end
        JOY_LOAD = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (frame_done) early++;
        end
        vectors++;
        if (early !== 0) begin
            miscompares++;
            $display("FAIL abort_frame_done got=%0d exp=0", early);
        end
        exp_bits = 24'h7F_F000;    // ~{12'h800, 12'hFFF}
        early    = 0;
        for (int i = 0; i < 24; i++) begin
            if (i == 5) begin
                joystick1 = 12'h000;
                joystick2 = 12'h000;
            end
            vectors++;
            if (JOY_DATA !== exp_bits[i]) begin
                miscompares++;
                $display("FAIL reload_bit%0d got=%b exp=%b", i, JOY_DATA, exp_bits[i]);
            end
            do_rise(p);
            if (i == 23) last = p;
            else early += p;
        end
        vectors++;
        if ((early !== 0) || (last !== 1)) begin
            miscompares++;
            $display("FAIL reload_frame_done got=early%0d/last%0d exp=early0/last1", early, last);
        end
`ifdef DB15_RESP_STATS_EN
        vectors++;
        if (short_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL short_cnt got=%0d exp=1", short_cnt);
        end
        vectors++;
        if (frame_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL frame_cnt_after_reload got=%0d exp=2", frame_cnt);
        end
`endif
    endtask

    task automatic test_idle_timeout;
        int n;
        int m;
        JOY_LOAD = 1'b0;
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            if (n == 4) JOY_LOAD = 1'b1;
            if (n == 10) begin
                vectors++;
                if (link_idle !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_after_load got=%b exp=0", link_idle);
                end
            end
            if ((n > 10) && link_idle) break;
        end
        // 2 sync stages + 1 clear cycle + TIMEOUT counts
        vectors++;
        if (n !== TIMEOUT + 3) begin
            miscompares++;
            $display("FAIL idle_assert_cycle got=%0d exp=%0d", n, TIMEOUT + 3);
        end
        JOY_LOAD = 1'b0;
        m = 0;
        while (m < 20) begin
            @(negedge clk);
            m++;
            if (!link_idle) break;
        end
        vectors++;
        if (m !== 3) begin
            miscompares++;
            $display("FAIL idle_deassert_cycle got=%0d exp=3", m);
        end
        repeat (4) @(negedge clk);
        JOY_LOAD = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        int p;
        int total;
        do_load(12'hFFF, 12'hFFF, p);
        for (int i = 0; i < 7; i++) do_rise(p);
        vectors++;
        if (JOY_DATA !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_reset_bit7 got=%b exp=0", JOY_DATA);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (JOY_DATA !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset_joy_data got=%b exp=1", JOY_DATA);
        end
        vectors++;
        if (link_idle !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset_link_idle got=%b exp=1", link_idle);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total = 0;
        for (int i = 0; i < 5; i++) begin
            do_rise(p);
            total += p;
            vectors++;
            if (JOY_DATA !== 1'b1) begin
                miscompares++;
                $display("FAIL no_load_bit%0d got=%b exp=1", i, JOY_DATA);
            end
        end
        vectors++;
        if (total !== 0) begin
            miscompares++;
            $display("FAIL no_load_frame_done got=%0d exp=0", total);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        JOY_CLK     = 1'b0;
        JOY_LOAD    = 1'b1;
        joystick1   = '0;
        joystick2   = '0;
        @(negedge clk);
        test_reset();
        test_full_frame();
        test_drained();
        test_short_frame();
        test_idle_timeout();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
